timer_counter: RTL

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_counter_pkg.sv | 37 +++
 rtl/timer_counter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Timer/counter shared definitions.
// FSM states, register offsets, CTRL fields, byte-merge helper.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_W    = 4;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Bridge-mapped down-counter timer with one-shot/auto-reload and irq.
// Ports: clk, reset, addr/we/byteen/wd (write), rd (comb read), irq.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  tc_state_e   state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_any;
  logic        en;
  logic        reload;
  logic [1:0]  mode;
  logic [27:0] ctrl_mrg_unused;
  logic [CTRL_W-1:0] ctrl_mrg;
  logic [31:0] preset_mrg;
  logic [27:0] addr_unused;

  assign off         = addr[3:2];
  assign addr_unused = addr[31:4];

  assign wr_ctrl   = we && (off == OFF_CTRL) && (|byteen);
  assign wr_preset = we && (off == OFF_PRESET) && (|byteen);
  assign wr_any    = wr_ctrl || wr_preset;

  assign en     = ctrl_q[CTRL_EN];
  assign mode   = ctrl_q[CTRL_MODE +: 2];
  assign reload = (mode == MODE_RELOAD);

  assign {ctrl_mrg_unused, ctrl_mrg} =
    byte_merge({28'd0, ctrl_q}, wd, byteen);
  assign preset_mrg =
    byte_merge(preset_q, wd, byteen);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // Zero and one both expire here, so COUNT never wraps.
          count_d = '0;
          state_d = ST_INT;
          flag_d  = 1'b1;
        end
      end
      ST_INT: begin
        if (reload) begin
          state_d = ST_LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bus write wins over whatever the FSM wanted this edge.
    if (wr_any) begin
      state_d  = ST_IDLE;
      flag_d   = 1'b0;
      count_d  = count_q;
      ctrl_d   = wr_ctrl ? ctrl_mrg : ctrl_q;
      preset_d = wr_preset ? preset_mrg : preset_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    rd = '0;
    case (off)
      OFF_CTRL:   rd = {28'd0, ctrl_q};
      OFF_PRESET: rd = preset_q;
      OFF_COUNT:  rd = count_q;
      default:    rd = '0;
    endcase
  end

  assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule
